// File: rtl/capture_streamer.sv
`default_nettype none
// ============================================================================
// capture_streamer
// Triggered 8-probe logic capture into a word buffer, streamed out to uart_tx.
// Revision: 1.0
// ============================================================================
module capture_streamer #(
    parameter int DEPTH_LOG2       = 8,
    parameter int SAMPLE_PRESCALER = 50
) (
    input  logic        i_clk,
    input  logic        _rst,
    input  logic [7:0]  probes,
    input  logic        arm,
    input  logic        abort,
    input  logic [7:0]  trig_mask,
    input  logic [7:0]  trig_value,
    output logic [31:0] tx_data,
    output logic        tx_fetch,
    output logic        tx_transmit,
    input  logic        tx_busy,
    output logic        armed,
    output logic        capturing,
    output logic        done
);

    localparam int WORDS_LOG2 = DEPTH_LOG2 - 2;
    // A one-word buffer still gets a 1-bit pointer; the second entry is never addressed.
    localparam int WA         = (WORDS_LOG2 > 0) ? WORDS_LOG2 : 1;
    localparam int MEM_WORDS  = 1 << WA;
    localparam int PW         = (SAMPLE_PRESCALER > 1) ? $clog2(SAMPLE_PRESCALER) : 1;

    localparam logic [PW-1:0]         PRESC_LAST  = PW'(SAMPLE_PRESCALER - 1);
    localparam logic [DEPTH_LOG2-1:0] SAMPLE_LAST = '1;
    localparam logic [WA-1:0]         WORD_LAST   = WA'((1 << WORDS_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARMED     = 3'd1,
        S_CAPTURE   = 3'd2,
        S_READ      = 3'd3,
        S_FETCH     = 3'd4,
        S_START     = 3'd5,
        S_WAIT_BUSY = 3'd6,
        S_WAIT_IDLE = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [DEPTH_LOG2-1:0] samp_q, samp_d;
    logic [23:0]           pack_q, pack_d;
    logic [WA-1:0]         wptr_q, wptr_d;
    logic [31:0]           tx_data_q, tx_data_d;
    logic                  done_q, done_d;

    logic                  w_mem_we;
    logic [31:0]           w_mem_wdata;
    logic [WA-1:0]         w_waddr;
    logic                  w_trig_hit;
    logic                  w_sample_tick;

    logic [31:0]           mem [MEM_WORDS];

    generate
        if (DEPTH_LOG2 > 2) begin : g_waddr_multi
            assign w_waddr = samp_q[DEPTH_LOG2-1:2];
        end else begin : g_waddr_single
            assign w_waddr = '0;
        end
    endgenerate

    assign w_trig_hit    = ((probes ^ trig_value) & trig_mask) == 8'h00;
    assign w_sample_tick = (presc_q == '0);
    assign w_mem_wdata   = {probes, pack_q};

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        samp_d    = samp_q;
        pack_d    = pack_q;
        wptr_d    = wptr_q;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
        w_mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_ARMED;
                    presc_d = '0;
                    samp_d  = '0;
                    pack_d  = '0;
                    wptr_d  = '0;
                end
            end
            S_ARMED: begin
                if (w_trig_hit) begin
                    state_d = S_CAPTURE;
                    presc_d = '0;
                end
            end
            S_CAPTURE: begin
                presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
                if (w_sample_tick) begin
                    // The fourth sample of a word goes straight into the buffer with the three held bytes.
                    case (samp_q[1:0])
                        2'd0:    pack_d[7:0]   = probes;
                        2'd1:    pack_d[15:8]  = probes;
                        2'd2:    pack_d[23:16] = probes;
                        default: w_mem_we      = 1'b1;
                    endcase
                    if (samp_q == SAMPLE_LAST) begin
                        state_d = S_READ;
                        wptr_d  = '0;
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            S_READ: begin
                tx_data_d = mem[wptr_q];
                state_d   = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_START;
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (!tx_busy) begin
                    if (wptr_q == WORD_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wptr_d  = wptr_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            w_mem_we = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge _rst) begin
        if (!_rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            samp_q    <= '0;
            pack_q    <= '0;
            wptr_q    <= '0;
            tx_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            samp_q    <= samp_d;
            pack_q    <= pack_d;
            wptr_q    <= wptr_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
        end
    end

    // Buffer contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            mem[w_waddr] <= w_mem_wdata;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_fetch    = (state_q == S_FETCH);
    assign tx_transmit = (state_q == S_START);
    assign armed       = (state_q == S_ARMED);
    assign capturing   = (state_q == S_CAPTURE);
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_streamer.sv
`default_nettype none
// ============================================================================
// tb_capture_streamer
// Scoreboard bench: dut A (depth 4, prescaler 1) and dut B (depth 16, prescaler 3).
// Revision: 1.0
// ============================================================================
module tb_capture_streamer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  arm_v   = 2'b00;
    logic [1:0]  abort_v = 2'b00;
    logic [1:0]  force_v = 2'b00;
    logic [1:0]  busy_v  = 2'b00;
    logic [7:0]  probes_v [2];
    logic [7:0]  mask_v   [2];
    logic [7:0]  value_v  [2];

    wire  [31:0] txd_a, txd_b;
    wire  [1:0]  fetch_v, trans_v, armed_v, capt_v, done_v;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    int          exp_done  [2] = '{0, 0};
    int          fetch_cnt [2] = '{0, 0};
    int          bcnt      [2] = '{0, 0};
    logic        prev_fetch[2] = '{1'b0, 1'b0};
    logic [31:0] fdata     [2] = '{32'h0, 32'h0};

    always #5 clk = ~clk;

    capture_streamer #(.DEPTH_LOG2(2), .SAMPLE_PRESCALER(1)) u_dut_a (
        .i_clk(clk), ._rst(rst_n), .probes(probes_v[0]), .arm(arm_v[0]), .abort(abort_v[0]),
        .trig_mask(mask_v[0]), .trig_value(value_v[0]), .tx_data(txd_a), .tx_fetch(fetch_v[0]),
        .tx_transmit(trans_v[0]), .tx_busy(busy_v[0]), .armed(armed_v[0]),
        .capturing(capt_v[0]), .done(done_v[0])
    );

    capture_streamer #(.DEPTH_LOG2(4), .SAMPLE_PRESCALER(3)) u_dut_b (
        .i_clk(clk), ._rst(rst_n), .probes(probes_v[1]), .arm(arm_v[1]), .abort(abort_v[1]),
        .trig_mask(mask_v[1]), .trig_value(value_v[1]), .tx_data(txd_b), .tx_fetch(fetch_v[1]),
        .tx_transmit(trans_v[1]), .tx_busy(busy_v[1]), .armed(armed_v[1]),
        .capturing(capt_v[1]), .done(done_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // uart_tx model: busy rises in the transmit cycle and holds 5 (A) or 100 (B) cycles.
    always @(posedge clk) begin
        #2;
        for (int s = 0; s < 2; s++) begin
            if (trans_v[s]) bcnt[s] = (s == 0) ? 5 : 100;
            else if (bcnt[s] > 0) bcnt[s]--;
            busy_v[s] = (bcnt[s] > 0) || force_v[s];
        end
    end

    task automatic mon(input int s, input logic f, input logic t, input logic d,
                       input logic bsy, input logic frc, input logic [31:0] data);
        string p;
        int    qs;
        p = (s == 0) ? "a" : "b";
        if (f) begin
            chk({p, "_fetch_not_with_transmit"}, 32'(t), 32'd0);
            if (!frc) chk({p, "_no_fetch_while_busy"}, 32'(bsy), 32'd0);
            qs = (s == 0) ? qa.size() : qb.size();
            chk({p, "_fetch_word_pending"}, 32'(qs > 0), 32'd1);
            if (qs > 0) chk({p, "_word"}, data, (s == 0) ? qa.pop_front() : qb.pop_front());
            fdata[s] = data;
            fetch_cnt[s]++;
        end
        if (t) begin
            chk({p, "_transmit_follows_fetch"}, 32'(prev_fetch[s]), 32'd1);
            chk({p, "_tx_data_stable"}, data, fdata[s]);
        end else if (prev_fetch[s]) begin
            chk({p, "_transmit_after_fetch"}, 32'(t), 32'd1);
        end
        if (d) begin
            qs = (s == 0) ? qa.size() : qb.size();
            chk({p, "_done_expected"}, 32'(exp_done[s] > 0), 32'd1);
            chk({p, "_done_after_last_word"}, 32'(qs), 32'd0);
            if (exp_done[s] > 0) exp_done[s]--;
        end
        prev_fetch[s] = f;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_fetch[0] = 1'b0;
            prev_fetch[1] = 1'b0;
        end else begin
            mon(0, fetch_v[0], trans_v[0], done_v[0], busy_v[0], force_v[0], txd_a);
            mon(1, fetch_v[1], trans_v[1], done_v[1], busy_v[1], force_v[1], txd_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input logic [7:0] base, input int k, input int presc);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = base + 8'((4 * k + j) * presc);
        return w;
    endfunction

    // Arm with mask=0; sample c of the capture window carries base+c.
    task automatic capture(input int s, input int nwords, input int presc, input logic [7:0] base);
        arm_v[s] = 1'b1;
        probes_v[s] = 8'hEE;
        tick();
        arm_v[s] = 1'b0;
        chk($sformatf("%0d_armed", s), 32'(armed_v[s]), 32'd1);
        tick();
        chk($sformatf("%0d_capturing", s), 32'(capt_v[s]), 32'd1);
        for (int c = 0; c <= (nwords * 4 - 1) * presc; c++) begin
            probes_v[s] = base + 8'(c);
            tick();
        end
    endtask

    task automatic wait_done(input int s, input int budget);
        int n = 0;
        while (exp_done[s] != 0 && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("%0d_done_within_budget", s), 32'(exp_done[s]), 32'd0);
    endtask

    task automatic wait_fetch(input int s, input int target, input int budget);
        int n = 0;
        while (fetch_cnt[s] < target && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("%0d_fetch_count", s), 32'(fetch_cnt[s]), 32'(target));
    endtask

    task automatic check_idle_outputs(input int s, input string tag);
        chk({tag, "_tx_data"}, (s == 0) ? txd_a : txd_b, 32'h0);
        chk({tag, "_fetch"}, 32'(fetch_v[s]), 32'd0);
        chk({tag, "_transmit"}, 32'(trans_v[s]), 32'd0);
        chk({tag, "_armed"}, 32'(armed_v[s]), 32'd0);
        chk({tag, "_capturing"}, 32'(capt_v[s]), 32'd0);
        chk({tag, "_done"}, 32'(done_v[s]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation still running, required finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int s = 0; s < 2; s++) begin
            probes_v[s] = 8'h00;
            mask_v[s]   = 8'h00;
            value_v[s]  = 8'h00;
        end
        tick();
        tick();
        check_idle_outputs(0, "reset_a");
        check_idle_outputs(1, "reset_b");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single word, prescaler 1
        capture(0, 1, 1, 8'h10);
        qa.push_back(32'h13121110);
        exp_done[0]++;
        wait_done(0, 100);
        chk("a_idle_after_done", 32'(armed_v[0]), 32'd0);
        chk("a_tx_data_held", txd_a, 32'h13121110);

        // abort wins over arm in IDLE
        arm_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        tick();
        arm_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("a_abort_beats_arm", 32'(armed_v[0]), 32'd0);
        tick();

        // masked trigger on probes[0]
        mask_v[0] = 8'h01;
        value_v[0] = 8'h01;
        arm_v[0] = 1'b1;
        probes_v[0] = 8'hFE;
        tick();
        arm_v[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("a_armed_waiting", 32'({armed_v[0], capt_v[0]}), 32'b10);
            probes_v[0] = 8'hFE;
            tick();
        end
        chk("a_armed_before_trigger", 32'(armed_v[0]), 32'd1);
        probes_v[0] = 8'h01;
        tick();
        chk("a_capturing_after_trigger", 32'(capt_v[0]), 32'd1);
        probes_v[0] = 8'h21; tick();
        probes_v[0] = 8'h23; tick();
        probes_v[0] = 8'h25; tick();
        probes_v[0] = 8'h27; tick();
        qa.push_back(32'h27252321);
        exp_done[0]++;
        wait_done(0, 100);
        mask_v[0] = 8'h00;
        value_v[0] = 8'h00;

        // uart already busy at fetch time
        force_v[0] = 1'b1;
        base = fetch_cnt[0];
        capture(0, 1, 1, 8'h80);
        qa.push_back(32'h83828180);
        exp_done[0]++;
        wait_fetch(0, base + 1, 50);
        repeat (10) tick();
        chk("a_held_while_busy", 32'(exp_done[0]), 32'd1);
        force_v[0] = 1'b0;
        wait_done(0, 100);

        // four words, prescaler 3, slow uart
        base = fetch_cnt[1];
        capture(1, 4, 3, 8'h40);
        for (int k = 0; k < 4; k++) qb.push_back(exp_word(8'h40, k, 3));
        exp_done[1]++;
        wait_done(1, 1000);
        chk("b_four_fetches", 32'(fetch_cnt[1] - base), 32'd4);

        // abort while waiting for word 1 to finish
        base = fetch_cnt[1];
        capture(1, 4, 3, 8'h90);
        qb.push_back(exp_word(8'h90, 0, 3));
        qb.push_back(exp_word(8'h90, 1, 3));
        wait_fetch(1, base + 2, 400);
        repeat (10) tick();
        abort_v[1] = 1'b1;
        tick();
        abort_v[1] = 1'b0;
        chk("b_abort_no_transmit", 32'(trans_v[1]), 32'd0);
        repeat (150) tick();
        chk("b_no_fetch_after_abort", 32'(fetch_cnt[1] - base), 32'd2);

        // fresh capture after abort
        capture(1, 4, 3, 8'h20);
        for (int k = 0; k < 4; k++) qb.push_back(exp_word(8'h20, k, 3));
        exp_done[1]++;
        wait_done(1, 1000);

        // asynchronous reset in the middle of a capture
        arm_v[1] = 1'b1;
        tick();
        arm_v[1] = 1'b0;
        tick();
        chk("b_capturing_before_reset", 32'(capt_v[1]), 32'd1);
        repeat (5) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs(1, "async_reset_b");
        check_idle_outputs(0, "async_reset_a");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("b_idle_after_reset", 32'({armed_v[1], capt_v[1], fetch_v[1]}), 32'd0);
        capture(1, 4, 3, 8'h05);
        for (int k = 0; k < 4; k++) qb.push_back(exp_word(8'h05, k, 3));
        exp_done[1]++;
        wait_done(1, 1000);

        repeat (5) tick();
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/capture_streamer.md
CAPTURE_STREAMER -- requirements
Module: capture_streamer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning capture depth of 2^DEPTH_LOG2 samples (min 2, so depth is a multiple of 4).
REQ-002 SHALL have parameter SAMPLE_PRESCALER, default 50, meaning i_clk cycles per sample (min 1; 50 = 1 MS/s at 50 MHz).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port _rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port probes, input, 8, probe lines, already synchronised to i_clk.
REQ-006 SHALL have port arm, input, 1, single-cycle pulse that starts a capture.
REQ-007 SHALL have port abort, input, 1, level; returns the block to IDLE.
REQ-008 SHALL have port trig_mask, input, 8, probe bits taking part in the trigger compare.
REQ-009 SHALL have port trig_value, input, 8, required levels of the masked probe bits.
REQ-010 SHALL have port tx_data, output, 32, word for uart_tx data.
REQ-011 SHALL have port tx_fetch, output, 1, load strobe for uart_tx fetch.
REQ-012 SHALL have port tx_transmit, output, 1, start strobe for uart_tx transmit.
REQ-013 SHALL have port tx_busy, input, 1, uart_tx busy.
REQ-014 SHALL have port armed, output, 1, high in ARMED.
REQ-015 SHALL have port capturing, output, 1, high in CAPTURE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse when the last word has finished transmitting.

Function
REQ-017 SHALL implement states IDLE, ARMED, CAPTURE, READ, FETCH, START, WAIT_BUSY and WAIT_IDLE.
REQ-018 IDLE SHALL go to ARMED on arm=1; in every other state arm SHALL be ignored.
REQ-019 ARMED SHALL go to CAPTURE in the first cycle where (probes & trig_mask) == (trig_value & trig_mask); trig_mask=0 triggers in the first ARMED cycle.
REQ-020 In CAPTURE the sample counter SHALL restart, so sample 0 is probes in the first CAPTURE cycle and sample n is taken n*SAMPLE_PRESCALER cycles later.
REQ-021 Samples SHALL be packed four per word: sample 4k into bits 7:0, 4k+1 into 15:8, 4k+2 into 23:16 and 4k+3 into 31:24.
REQ-022 Each completed word SHALL be written to an internal buffer of 2^(DEPTH_LOG2-2) x 32 at word address k.
REQ-023 After sample 2^DEPTH_LOG2-1 is written, the state SHALL go to READ with word pointer 0.
REQ-024 READ SHALL issue a synchronous buffer read (one-cycle latency) and register the result into tx_data on entry to FETCH.
REQ-025 FETCH SHALL assert tx_fetch for exactly one cycle, then go to START.
REQ-026 START SHALL assert tx_transmit for exactly one cycle, then go to WAIT_BUSY.
REQ-027 tx_data SHALL stay stable from FETCH until the next READ.
REQ-028 tx_fetch and tx_transmit SHALL never be high in the same cycle.
REQ-029 WAIT_BUSY SHALL go to WAIT_IDLE when tx_busy=1.
REQ-030 WAIT_IDLE SHALL act on tx_busy=0: if the word pointer is not the last, increment it and go to READ; if it is the last, pulse done and go to IDLE.
REQ-031 Wrap-around: the word pointer and sample address SHALL wrap to 0 only on re-arm, and the buffer SHALL never be over-written during streaming.
REQ-032 abort=1 SHALL force IDLE on the next edge from any state, deassert all strobes and not pulse done; a word already handed to uart_tx completes there unaffected.
REQ-033 abort and arm together in IDLE SHALL leave the block in IDLE (abort has priority).
REQ-034 If tx_busy is already 1 in FETCH, the block SHALL still follow FETCH->START->WAIT_BUSY; it SHALL not wait before fetch.

Reset
REQ-035 _rst=0 SHALL immediately force IDLE with tx_data=0, tx_fetch=0, tx_transmit=0, armed=0, capturing=0, done=0, and all counters and pointers at 0.
REQ-036 Buffer contents SHALL not be cleared by reset.
REQ-037 Reset released mid-stream SHALL leave the block in IDLE with no strobes until the next arm.

Verification
REQ-038 DEPTH_LOG2=2, PRESCALER=1, mask=0, probes counting 0x10,0x11,0x12,0x13 from the arm+1 cycle -> exactly one word, tx_data=0x13121110, one fetch then one transmit pulse, done after tx_busy falls.
REQ-039 mask=0x01, value=0x01, probes[0] rising 20 cycles after arm -> armed=1 for those 20 cycles, first sample has bit0=1.
REQ-040 DEPTH_LOG2=4 with a uart_tx model holding busy for 100 cycles -> 4 words in address order, one fetch/transmit pair each, no new fetch while busy=1.
REQ-041 abort asserted in WAIT_IDLE of word 1 -> IDLE next cycle, no further fetch, done stays 0; a later arm starts a fresh capture.
REQ-042 _rst pulsed low during CAPTURE, asynchronous to i_clk -> all outputs 0 immediately; arm after release restarts correctly.
REQ-043 PRESCALER=3 -> samples spaced exactly 3 cycles apart, confirmed via the packed tx_data.
